// File: rtl/x7seg_scan_multi.sv
// x7seg_scan_multi
// Multiplexed seven-segment display controller for N_DIGITS hex digits.
// Frames are double-buffered (staging -> active only at a frame boundary),
// brightness is PWM controlled, and digits can be blanked, blinked or
// leading-zero blanked.
//
// Ports:
//   sys_clk, sys_rst  clock and synchronous active-high reset
//   load              one-cycle strobe capturing digits/dp_in/blank_in/blink_in
//   digits            nibble per digit, digit 0 rightmost
//   dp_in             decimal point per digit (1 = lit)
//   blank_in          1 = digit dark
//   blink_in          1 = digit blinks
//   brightness        PWM duty, all-ones = full on, 0 = off
//   lzb_en            leading-zero blanking enable
//   an                anode enables, active-low (registered)
//   seg               segments a..g, active-low (registered)
//   dp                decimal point, active-low (registered)
//   pending           staging holds data not yet displayed
//   frame_start       one-cycle pulse when the slot index wraps to 0
module x7seg_scan_multi #(
  parameter int N_DIGITS     = 8,
  parameter int TICK_DIV     = 100000,
  parameter int GUARD        = 16,
  parameter int BRIGHT_W     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic [N_DIGITS-1:0]   blink_in,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  lzb_en,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  pending,
  output logic                  frame_start
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);

  // Hex nibble to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
  logic [FRM_W-1:0]      frm_q, frm_d;
  logic                  phase_q, phase_d;
  logic [4*N_DIGITS-1:0] stg_dig_q, stg_dig_d, act_dig_q, act_dig_d;
  logic [N_DIGITS-1:0]   stg_dp_q, stg_dp_d, act_dp_q, act_dp_d;
  logic [N_DIGITS-1:0]   stg_blank_q, stg_blank_d, act_blank_q, act_blank_d;
  logic [N_DIGITS-1:0]   stg_blink_q, stg_blink_d, act_blink_q, act_blink_d;
  logic                  pending_q, pending_d;
  logic                  fs_q, fs_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  tick_s, boundary_s, on_s, lead_s;
  logic [N_DIGITS-1:0]   lzb_s, dark_s;

  // Next-state logic for timing, buffers, blink and the output drive.
  always_comb begin
    tick_s     = (cnt_q == CNT_MAX);
    boundary_s = tick_s && (idx_q == IDX_MAX);

    cnt_d = tick_s ? '0 : cnt_q + CNT_W'(1);
    if (tick_s) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end
    pwm_d = pwm_q + BRIGHT_W'(1);
    fs_d  = boundary_s;

    // Blink phase flips once every BLINK_FRAMES frames.
    frm_d   = frm_q;
    phase_d = phase_q;
    if (boundary_s) begin
      if (frm_q == FRM_MAX) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end else begin
      frm_d = frm_q;
    end

    // Active copies the old staging contents before a coincident load lands,
    // so a load on the boundary tick is shown one frame later.
    act_dig_d   = act_dig_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    act_blink_d = act_blink_q;
    pending_d   = pending_q;
    if (boundary_s && pending_q) begin
      act_dig_d   = stg_dig_q;
      act_dp_d    = stg_dp_q;
      act_blank_d = stg_blank_q;
      act_blink_d = stg_blink_q;
      pending_d   = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    stg_dig_d   = stg_dig_q;
    stg_dp_d    = stg_dp_q;
    stg_blank_d = stg_blank_q;
    stg_blink_d = stg_blink_q;
    if (load) begin
      stg_dig_d   = digits;
      stg_dp_d    = dp_in;
      stg_blank_d = blank_in;
      stg_blink_d = blink_in;
      pending_d   = 1'b1;
    end else begin
      stg_dig_d = stg_dig_q;
    end

    // Leading-zero scan from the leftmost digit; digit 0 is always kept.
    lzb_s  = '0;
    lead_s = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (lead_s && (act_dig_q[4*i +: 4] == 4'h0) && !act_dp_q[i]) begin
        lzb_s[i] = 1'b1;
      end else begin
        lead_s = 1'b0;
      end
    end

    dark_s = act_blank_q | (act_blink_q & {N_DIGITS{phase_q}})
             | (lzb_s & {N_DIGITS{lzb_en}});
    on_s   = (brightness == {BRIGHT_W{1'b1}}) || (pwm_q < brightness);

    an_d = '1;
    if ((cnt_q >= GUARD_C) && on_s && !dark_s[idx_q]) begin
      an_d[idx_q] = 1'b0;
    end else begin
      an_d = '1;
    end
    seg_d = hex_to_seg(act_dig_q[{idx_q, 2'b00} +: 4]);
    dp_d  = ~act_dp_q[idx_q];
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pwm_q       <= '0;
      frm_q       <= '0;
      phase_q     <= 1'b0;
      stg_dig_q   <= '0;
      stg_dp_q    <= '0;
      stg_blank_q <= '1;
      stg_blink_q <= '0;
      act_dig_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '1;
      act_blink_q <= '0;
      pending_q   <= 1'b0;
      fs_q        <= 1'b0;
      an_q        <= '1;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pwm_q       <= pwm_d;
      frm_q       <= frm_d;
      phase_q     <= phase_d;
      stg_dig_q   <= stg_dig_d;
      stg_dp_q    <= stg_dp_d;
      stg_blank_q <= stg_blank_d;
      stg_blink_q <= stg_blink_d;
      act_dig_q   <= act_dig_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      act_blink_q <= act_blink_d;
      pending_q   <= pending_d;
      fs_q        <= fs_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign pending     = pending_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_x7seg_scan_multi.sv
module tb_x7seg_scan_multi;
  localparam int N  = 4;
  localparam int TD = 8;
  localparam int G  = 1;
  localparam int BW = 2;
  localparam int BF = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        load = 1'b0;
  logic        lzb_en = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_in = 4'h0;
  logic [3:0]  blink_in = 4'h0;
  logic [1:0]  brightness = 2'b11;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp, pending, frame_start;

  int n_chk = 0;
  int n_pass = 0;

  x7seg_scan_multi #(.N_DIGITS(N), .TICK_DIV(TD), .GUARD(G), .BRIGHT_W(BW),
                     .BLINK_FRAMES(BF)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .load(load), .digits(digits),
    .dp_in(dp_in), .blank_in(blank_in), .blink_in(blink_in),
    .brightness(brightness), .lzb_en(lzb_en), .an(an), .seg(seg), .dp(dp),
    .pending(pending), .frame_start(frame_start));

  always #5 sys_clk = ~sys_clk;

  // Segment patterns as listed in the decode table.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: time is a cycle count since reset; slot, position,
  // PWM value and frame number are derived from it arithmetically.
  bit          m_valid = 0;
  int          m_t = 0;
  logic [15:0] m_stg_dig, m_act_dig;
  logic [3:0]  m_stg_dp, m_stg_blank, m_stg_blink;
  logic [3:0]  m_act_dp, m_act_blank, m_act_blink;
  logic        m_pend, m_fs, m_dp;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;

  task automatic model_clock();
    int cnt, idx, pwm, fr;
    bit ph, lit, lead;
    logic [3:0] dark;
    if (sys_rst) begin
      m_valid = 1; m_t = 0;
      m_stg_dig = 16'h0; m_stg_dp = 4'h0; m_stg_blank = 4'hF; m_stg_blink = 4'h0;
      m_act_dig = 16'h0; m_act_dp = 4'h0; m_act_blank = 4'hF; m_act_blink = 4'h0;
      m_pend = 1'b0; m_fs = 1'b0; m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
      return;
    end
    if (!m_valid) return;
    cnt = m_t % TD;
    idx = (m_t / TD) % N;
    pwm = m_t % (1 << BW);
    fr  = m_t / (TD * N);
    ph  = ((fr / BF) % 2) == 1;
    dark = m_act_blank | (ph ? m_act_blink : 4'h0);
    if (lzb_en) begin
      lead = 1;
      for (int i = N - 1; i >= 1; i--) begin
        if (lead && m_act_dig[4*i +: 4] == 4'h0 && !m_act_dp[i]) dark[i] = 1'b1;
        else lead = 0;
      end
    end
    lit = (cnt >= G) && ((brightness == 2'b11) || (pwm < int'(brightness))) && !dark[idx];
    m_an = 4'hF;
    if (lit) m_an[idx] = 1'b0;
    m_seg = seg_tab[m_act_dig[4*idx +: 4]];
    m_dp  = !m_act_dp[idx];
    m_fs  = (cnt == TD - 1) && (idx == N - 1);
    if (m_fs && m_pend) begin
      m_act_dig = m_stg_dig; m_act_dp = m_stg_dp;
      m_act_blank = m_stg_blank; m_act_blink = m_stg_blink;
      m_pend = 1'b0;
    end
    if (load) begin
      m_stg_dig = digits; m_stg_dp = dp_in;
      m_stg_blank = blank_in; m_stg_blink = blink_in;
      m_pend = 1'b1;
    end
    m_t++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock: update the model, clock the DUT, compare against the model.
  task automatic cyc();
    model_clock();
    @(posedge sys_clk);
    #1;
    if (m_valid) begin
      n_chk++;
      if (an === m_an && seg === m_seg && dp === m_dp && pending === m_pend &&
          frame_start === m_fs) begin
        n_pass++;
      end else if (n_chk - n_pass <= 20) begin
        $display("FAIL model t=%0d an=%b/%b seg=%h/%h dp=%b/%b pend=%b/%b fs=%b/%b",
                 m_t, an, m_an, seg, m_seg, dp, m_dp, pending, m_pend, frame_start, m_fs);
      end
    end
    load = 1'b0;
  endtask

  task automatic adv(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  task automatic wait_fs();
    bit seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      cyc();
      if (frame_start === 1'b1) seen = 1;
    end
    chk("wait_frame_start", {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_pclr();
    bit seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      cyc();
      if (pending === 1'b0) seen = 1;
    end
    chk("wait_pending_clear", {31'd0, seen}, 32'd1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dpv,
                         input logic [3:0] blk, input logic [3:0] bli);
    digits = d; dp_in = dpv; blank_in = blk; blink_in = bli;
    load = 1'b1;
    cyc();
  endtask

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dpv;
    logic [3:0]  blk;
    logic        lz;
    int          slot;
    logic [3:0]  an_e;
    logic [6:0]  seg_e;
    logic        dp_e;
  } vec_t;

  vec_t vt [20];
  int   lit_cnt;
  bit   lit_f [8];

  initial begin
    vt[0]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'h19, 1'b1};
    vt[1]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 3, 4'b0111, 7'h79, 1'b1};
    vt[2]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 3, 4'b1111, 7'h40, 1'b1};
    vt[3]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 2, 4'b1111, 7'h40, 1'b1};
    vt[4]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 1, 4'b1101, 7'h12, 1'b1};
    vt[5]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 0, 4'b1110, 7'h40, 1'b1};
    vt[6]  = '{16'h0050, 4'h4, 4'h0, 1'b1, 2, 4'b1011, 7'h40, 1'b0};
    vt[7]  = '{16'h0050, 4'h4, 4'h0, 1'b1, 3, 4'b1111, 7'h40, 1'b1};
    vt[8]  = '{16'h89AB, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'h03, 1'b1};
    vt[9]  = '{16'h89AB, 4'h0, 4'h0, 1'b0, 1, 4'b1101, 7'h08, 1'b1};
    vt[10] = '{16'h89AB, 4'h0, 4'h0, 1'b0, 2, 4'b1011, 7'h10, 1'b1};
    vt[11] = '{16'h89AB, 4'h0, 4'h0, 1'b0, 3, 4'b0111, 7'h00, 1'b1};
    vt[12] = '{16'hCDEF, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'h0E, 1'b1};
    vt[13] = '{16'hCDEF, 4'h0, 4'h0, 1'b0, 1, 4'b1101, 7'h06, 1'b1};
    vt[14] = '{16'hCDEF, 4'h0, 4'h0, 1'b0, 2, 4'b1011, 7'h21, 1'b1};
    vt[15] = '{16'hCDEF, 4'h0, 4'h0, 1'b0, 3, 4'b0111, 7'h46, 1'b1};
    vt[16] = '{16'h0567, 4'h0, 4'h2, 1'b0, 1, 4'b1111, 7'h02, 1'b1};
    vt[17] = '{16'h0000, 4'h0, 4'h0, 1'b1, 0, 4'b1110, 7'h40, 1'b1};
    vt[18] = '{16'h0000, 4'h0, 4'h0, 1'b0, 3, 4'b0111, 7'h40, 1'b1};
    vt[19] = '{16'h0567, 4'h1, 4'h0, 1'b0, 0, 4'b1110, 7'h78, 1'b0};

    // Reset values.
    sys_rst = 1'b1;
    cyc();
    sys_rst = 1'b0;
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_pending", {31'd0, pending}, 32'd0);
    chk("rst_frame_start", {31'd0, frame_start}, 32'd0);

    // First load stays hidden until the frame boundary.
    brightness = 2'b11;
    do_load(16'h1234, 4'h0, 4'h0, 4'h0);
    chk("t1_pending_set", {31'd0, pending}, 32'd1);
    chk("t1_dark_before_frame", {28'd0, an}, 32'hF);
    wait_fs();
    chk("t1_pending_clear", {31'd0, pending}, 32'd0);
    adv(1);
    chk("t1_guard_an", {28'd0, an}, 32'hF);
    chk("t1_slot0_seg", {25'd0, seg}, 32'h19);
    adv(1);
    chk("t1_slot0_an_first", {28'd0, an}, 32'hE);
    adv(6);
    chk("t1_slot0_an_last", {28'd0, an}, 32'hE);
    adv(1);
    chk("t1_slot1_guard", {28'd0, an}, 32'hF);
    chk("t1_slot1_seg", {25'd0, seg}, 32'h30);
    adv(20);
    chk("t1_slot3_seg", {25'd0, seg}, 32'h79);
    chk("t1_slot3_an", {28'd0, an}, 32'h7);

    // Mid-frame load does not disturb the frame being shown.
    wait_fs();
    adv(9);
    do_load(16'h5678, 4'h0, 4'h0, 4'h0);
    adv(19);
    chk("t2_old_frame_seg", {25'd0, seg}, 32'h79);
    chk("t2_pending_held", {31'd0, pending}, 32'd1);
    wait_fs();
    chk("t2_pending_fall", {31'd0, pending}, 32'd0);
    adv(5);
    chk("t2_new_seg", {25'd0, seg}, 32'h00);

    // Load coincident with the boundary tick.
    do_load(16'h9ABC, 4'h0, 4'h0, 4'h0);
    adv(25);
    do_load(16'hDEF0, 4'h0, 4'h0, 4'h0);
    chk("t3_boundary_fs", {31'd0, frame_start}, 32'd1);
    chk("t3_pending_stays", {31'd0, pending}, 32'd1);
    adv(5);
    chk("t3_prev_staging_seg", {25'd0, seg}, 32'h46);
    wait_fs();
    chk("t3_pending_fall", {31'd0, pending}, 32'd0);
    adv(5);
    chk("t3_late_data_seg", {25'd0, seg}, 32'h40);

    // Table-driven decode / blanking vectors.
    for (int v = 0; v < 20; v++) begin
      lzb_en = vt[v].lz;
      do_load(vt[v].dig, vt[v].dpv, vt[v].blk, 4'h0);
      wait_pclr();
      adv(vt[v].slot * TD + 5);
      chk($sformatf("vec%0d_an", v), {28'd0, an}, {28'd0, vt[v].an_e});
      chk($sformatf("vec%0d_seg", v), {25'd0, seg}, {25'd0, vt[v].seg_e});
      chk($sformatf("vec%0d_dp", v), {31'd0, dp}, {31'd0, vt[v].dp_e});
    end
    lzb_en = 1'b0;

    // PWM duty: count lit cycles over one frame.
    brightness = 2'd1;
    do_load(16'h1234, 4'h0, 4'h0, 4'h0);
    wait_pclr();
    lit_cnt = 0;
    for (int i = 0; i < 32; i++) begin cyc(); if (an != 4'hF) lit_cnt++; end
    chk("t5_bright1_lit", lit_cnt, 32'd4);
    brightness = 2'd2;
    lit_cnt = 0;
    for (int i = 0; i < 32; i++) begin cyc(); if (an != 4'hF) lit_cnt++; end
    chk("t5_bright2_lit", lit_cnt, 32'd12);
    brightness = 2'd0;
    lit_cnt = 0;
    for (int i = 0; i < 32; i++) begin cyc(); if (an != 4'hF) lit_cnt++; end
    chk("t5_bright0_lit", lit_cnt, 32'd0);

    // Blink on digit 0: lit state alternates in 2-frame periods.
    brightness = 2'b11;
    do_load(16'h1234, 4'h0, 4'h0, 4'h1);
    wait_pclr();
    lit_cnt = 0;
    for (int f = 0; f < 8; f++) begin
      lit_f[f] = 0;
      for (int i = 0; i < 32; i++) begin cyc(); if (an[0] == 1'b0) lit_f[f] = 1; end
      if (lit_f[f]) lit_cnt++;
    end
    for (int f = 0; f < 6; f++)
      chk($sformatf("t5_blink_alt%0d", f), {31'd0, lit_f[f] ^ lit_f[f+2]}, 32'd1);
    chk("t5_blink_count", lit_cnt, 32'd4);

    // Reset in slot 2 with pending data.
    do_load(16'h1234, 4'h0, 4'h0, 4'h0);
    wait_pclr();
    do_load(16'h5678, 4'h0, 4'h0, 4'h0);
    adv(17);
    sys_rst = 1'b1;
    cyc();
    sys_rst = 1'b0;
    chk("t6_rst_an", {28'd0, an}, 32'hF);
    chk("t6_rst_seg", {25'd0, seg}, 32'h7F);
    chk("t6_rst_pending", {31'd0, pending}, 32'd0);
    chk("t6_rst_dp", {31'd0, dp}, 32'd1);
    lit_cnt = 0;
    for (int i = 0; i < 70; i++) begin cyc(); if (an != 4'hF) lit_cnt++; end
    chk("t6_dark_after_rst", lit_cnt, 32'd0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) begin
        for (int d = 0; d < N; d++)
          digits[4*d +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
        dp_in    = 4'($urandom_range(15)) & 4'($urandom_range(15));
        blank_in = 4'($urandom_range(15)) & 4'($urandom_range(15)) & 4'($urandom_range(15));
        blink_in = 4'($urandom_range(15)) & 4'($urandom_range(15));
        load = 1'b1;
      end
      if ($urandom_range(63) == 0) brightness = 2'($urandom_range(3));
      if ($urandom_range(127) == 0) lzb_en = ~lzb_en;
      sys_rst = ($urandom_range(699) == 0);
      cyc();
    end
    sys_rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/x7seg_scan_multi.md
Name: x7seg_scan_multi

Overview:
Parametrised multiplexed seven-segment display controller, the successor to the fixed 8-digit scanner. It takes N hex nibbles with per-digit decimal point, blank and blink controls, decodes them to active-low segments and time-multiplexes the anodes. Frame updates are double-buffered so the display never tears, and brightness is PWM-controlled. It sits between the LeNet result/status logic and the board display pins.

Parameters:
N_DIGITS, 8, number of digits/anodes (2..16)
TICK_DIV, 100000, sys_clk cycles per digit slot
GUARD, 16, cycles at start of each slot with all anodes off (anti-ghosting); GUARD < TICK_DIV
BRIGHT_W, 4, brightness control width
BLINK_FRAMES, 64, frames per blink half-period

Ports:
sys_clk  in  1  clock
sys_rst  in  1  reset; synchronous, active-high
load  in  1  one-cycle strobe: capture digits/dp_in/blank_in/blink_in into staging
digits  in  4*N_DIGITS  nibble per digit, digit i = digits[4i+3:4i]; digit 0 is rightmost
dp_in  in  N_DIGITS  decimal point per digit, 1 = lit
blank_in  in  N_DIGITS  1 = digit dark
blink_in  in  N_DIGITS  1 = digit blinks
brightness  in  BRIGHT_W  PWM duty; all-ones = full on, 0 = off
lzb_en  in  1  leading-zero blanking enable
an  out  N_DIGITS  anode enables, active-low
seg  out  7  segments active-low, seg[0]=a … seg[6]=g
dp  out  1  decimal point, active-low
pending  out  1  staging holds data not yet displayed
frame_start  out  1  one-cycle pulse when slot index wraps to 0

Behaviour:
- Reset (sys_rst=1 at posedge): an all ones, seg=7'h7F, dp=1, pending=0, frame_start=0; prescaler, slot index, PWM counter, frame counter and blink phase = 0; staging/active digits=0, active blank all ones (dark until first frame applied).
- Prescaler cnt counts 0..TICK_DIV-1 and wraps; tick = (cnt==TICK_DIV-1). Slot index idx advances on tick, wrapping N_DIGITS-1 -> 0; frame_start pulses the cycle idx becomes 0.
- Double buffer: load=1 writes inputs to staging, pending<=1. At frame boundary (tick with idx==N_DIGITS-1): if pending, active<=staging and pending<=0. If load coincides with the boundary, active takes previous staging contents, staging takes new inputs, pending stays 1. Active set never changes mid-frame.
- Blink: frame counter increments on each frame boundary and wraps at BLINK_FRAMES-1; blink_phase toggles on wrap. blink_phase=1 blanks digits with active blink bit set.
- Leading-zero blanking (lzb_en=1): digits from N_DIGITS-1 downward with value 0 and dp 0 are blanked until the first non-zero or dp digit; digit 0 is never LZB-blanked. Combinational on active set.
- PWM: free-running BRIGHT_W-bit counter pwm, +1 every cycle. on = (brightness all-ones) or (pwm < brightness).
- Anode drive: an[idx]=0 only when cnt >= GUARD, on=1, and digit idx not blanked (blank, blink or LZB); all other bits 1.
- Decode (hex, active-low g..a): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E. dp = ~active dp[idx]. seg/dp driven regardless of anode state.
- an/seg/dp registered: reflect idx/cnt with one cycle latency.
- Reset mid-operation: next cycle all outputs at reset values and staging discarded.

Test Plan:
(N_DIGITS=4, TICK_DIV=8, GUARD=1, BRIGHT_W=2, BLINK_FRAMES=2 unless stated)
1. Reset then load digits=16'h1234, brightness=3 -> an=4'hF, pending=1 until first frame boundary; next frame slot 0: an=4'b1110 for cycles 1..7 of slot, seg=7'h19; slot 3: seg=7'h79.
2. Load 16'h5678 during slot 1 -> remaining slots of that frame still show 1234; new values from next frame_start; pending falls at boundary.
3. Load coincident with boundary tick -> active = previous staging, pending stays 1, new data appears one frame later.
4. digits=16'h0050, lzb_en=1 -> an[3],an[2] stay 1; digit 1 seg=7'h12; digit 0 seg=7'h40; set dp_in[2] -> digit 2 shows 0 with dp=0, digit 3 still dark.
5. brightness=1 -> an[idx] low exactly where pwm==0 and cnt>=1; brightness=0 -> an all ones; blink_in[0]=1 -> digit 0 dark in alternating 2-frame periods.
6. Assert sys_rst for one cycle in slot 2 with pending=1 -> next cycle an=4'hF, seg=7'h7F, pending=0; display dark until next load + boundary.
